// File: rtl/dram_port_arbiter.sv
// Three-requester arbiter onto a single DRAM command port, one transaction in flight, watchdog retire.
// Define DRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module dram_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_async,
  input  logic [2:0]              req_valid_i,
  input  logic [3*ADDR_W-1:0]     req_addr_i,
  input  logic [3*DATA_W-1:0]     req_wdata_i,
  input  logic [3*(DATA_W/8)-1:0] req_we_i,
  output logic [2:0]              req_ready_o,
  output logic [2:0]              rsp_valid_o,
  output logic [DATA_W-1:0]       rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    dram_oe_o,
  output logic [ADDR_W-1:0]       dram_addr_o,
  output logic [DATA_W-1:0]       dram_wdata_o,
  output logic [DATA_W/8-1:0]     dram_we_o,
  input  logic                    dram_busy_i,
  input  logic                    dram_valid_i,
  input  logic [DATA_W-1:0]       dram_rdata_i,
  output logic                    timeout_flag_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t            state_q;
  logic [1:0]        owner_q;
  logic [1:0]        owner_d;
  logic [2:0]        grant_d;
  logic              accept_d;
  logic [CNT_W-1:0]  wdog_q;

  logic              oe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   we_q;
  logic [2:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              timeout_flag_q;

`ifdef DRAM_ARB_RR_EN
  logic [1:0] ptr_q;

  // Search begins at the requester after the most recently accepted owner.
  always_comb begin
    grant_d = 3'b000;
    case (ptr_q)
      2'd1: begin
        if (req_valid_i[1])      grant_d = 3'b010;
        else if (req_valid_i[2]) grant_d = 3'b100;
        else if (req_valid_i[0]) grant_d = 3'b001;
      end
      2'd2: begin
        if (req_valid_i[2])      grant_d = 3'b100;
        else if (req_valid_i[0]) grant_d = 3'b001;
        else if (req_valid_i[1]) grant_d = 3'b010;
      end
      default: begin
        if (req_valid_i[0])      grant_d = 3'b001;
        else if (req_valid_i[1]) grant_d = 3'b010;
        else if (req_valid_i[2]) grant_d = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      ptr_q <= 2'd0;
    end else if (accept_d) begin
      ptr_q <= (owner_d == 2'd2) ? 2'd0 : owner_d + 2'd1;
    end
  end
`else
  always_comb begin
    grant_d = 3'b000;
    if (req_valid_i[0])      grant_d = 3'b001;
    else if (req_valid_i[1]) grant_d = 3'b010;
    else if (req_valid_i[2]) grant_d = 3'b100;
  end
`endif

  always_comb begin
    owner_d = 2'd0;
    if (grant_d[1]) owner_d = 2'd1;
    if (grant_d[2]) owner_d = 2'd2;
  end

  assign accept_d    = (state_q == S_IDLE) && (|grant_d);
  assign req_ready_o = ((state_q == S_IDLE) && !rst_async) ? grant_d : 3'b000;

  // Transaction sequencer; every DRAM-side and response output is a register here.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q        <= S_IDLE;
      owner_q        <= 2'd0;
      wdog_q         <= '0;
      oe_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      we_q           <= '0;
      rsp_valid_q    <= 3'b000;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      rsp_valid_q <= 3'b000;
      rsp_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            owner_q <= owner_d;
            addr_q  <= req_addr_i[int'(owner_d)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata_i[int'(owner_d)*DATA_W +: DATA_W];
            we_q    <= req_we_i[int'(owner_d)*BE_W +: BE_W];
            oe_q    <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!dram_busy_i) begin
            oe_q    <= 1'b0;
            wdog_q  <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response landing on the final watchdog cycle still counts as a success.
          if (dram_valid_i) begin
            rsp_valid_q <= 3'b001 << owner_q;
            rsp_rdata_q <= dram_rdata_i;
            state_q     <= S_IDLE;
          end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
            rsp_valid_q    <= 3'b001 << owner_q;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b1;
            timeout_flag_q <= 1'b1;
            state_q        <= S_IDLE;
          end else if (wdog_q != CNT_W'(TIMEOUT)) begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dram_oe_o      = oe_q;
  assign dram_addr_o    = addr_q;
  assign dram_wdata_o   = wdata_q;
  assign dram_we_o      = we_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_err_o      = rsp_err_q;
  assign timeout_flag_o = timeout_flag_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed scenarios plus randomized traffic against a transaction model.
// Build with +define+DRAM_ARB_RR_EN to check the round-robin variant.
module tb_dram_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;
  localparam int TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  rst_async = 1'b0;
  logic [2:0]            reqValid = '0;
  logic [3*ADDR_W-1:0]   reqAddr = '0;
  logic [3*DATA_W-1:0]   reqWdata = '0;
  logic [3*BE_W-1:0]     reqWe = '0;
  logic                  dramBusy = 1'b0;
  logic                  dramValid = 1'b0;
  logic [DATA_W-1:0]     dramRdata = '0;

  logic [2:0]            reqReady;
  logic [2:0]            rspValid;
  logic [DATA_W-1:0]     rspRdata;
  logic                  rspErr;
  logic                  dramOe;
  logic [ADDR_W-1:0]     dramAddr;
  logic [DATA_W-1:0]     dramWdata;
  logic [BE_W-1:0]       dramWe;
  logic                  timeoutFlag;

  dram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_async     (rst_async),
    .req_valid_i   (reqValid),
    .req_addr_i    (reqAddr),
    .req_wdata_i   (reqWdata),
    .req_we_i      (reqWe),
    .req_ready_o   (reqReady),
    .rsp_valid_o   (rspValid),
    .rsp_rdata_o   (rspRdata),
    .rsp_err_o     (rspErr),
    .dram_oe_o     (dramOe),
    .dram_addr_o   (dramAddr),
    .dram_wdata_o  (dramWdata),
    .dram_we_o     (dramWe),
    .dram_busy_i   (dramBusy),
    .dram_valid_i  (dramValid),
    .dram_rdata_i  (dramRdata),
    .timeout_flag_o(timeoutFlag)
  );

  always #5 clk = ~clk;

  int checksTotal = 0;
  int checksPassed = 0;
  int cyc = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Reference model: a transaction record tracked through request, command transfer and response.
  bit                mActive = 0;
  bit                mXfer = 0;
  int                mOwner = 0;
  int                mWaitCycles = 0;
  int                mStart = 0;
  int                mWho = 0;
  logic [ADDR_W-1:0] mAddr = '0;
  logic [DATA_W-1:0] mWdata = '0;
  logic [BE_W-1:0]   mWe = '0;
  logic [2:0]        mRspValid = '0;
  logic [DATA_W-1:0] mRspData = '0;
  bit                mRspErr = 0;
  bit                mFlag = 0;

  function automatic int pickOwner(input logic [2:0] v, input int start);
    for (int k = 0; k < 3; k++) begin
      if (v[(start + k) % 3]) return (start + k) % 3;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      mActive = 0; mXfer = 0; mStart = 0; mRspValid = '0; mRspData = '0;
      mRspErr = 0; mFlag = 0; mAddr = '0; mWdata = '0; mWe = '0;
    end else begin
      mRspValid = '0;
      mRspErr = 0;
      if (!mActive) begin
        mWho = pickOwner(reqValid, mStart);
        if (mWho >= 0) begin
          mActive = 1;
          mXfer = 0;
          mOwner = mWho;
          mAddr = reqAddr[mWho*ADDR_W +: ADDR_W];
          mWdata = reqWdata[mWho*DATA_W +: DATA_W];
          mWe = reqWe[mWho*BE_W +: BE_W];
`ifdef DRAM_ARB_RR_EN
          mStart = (mWho + 1) % 3;
`endif
        end
      end else if (!mXfer) begin
        if (!dramBusy) begin
          mXfer = 1;
          mWaitCycles = 0;
        end
      end else begin
        mWaitCycles++;
        if (dramValid) begin
          mRspValid = 3'b001 << mOwner;
          mRspData = dramRdata;
          mActive = 0;
        end else if (mWaitCycles >= TIMEOUT) begin
          mRspValid = 3'b001 << mOwner;
          mRspData = '0;
          mRspErr = 1;
          mFlag = 1;
          mActive = 0;
        end
      end
    end
  end

  logic [2:0] expReady;
  int         readyWho;

  // Compare every cycle at the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    expReady = 3'b000;
    if (!rst_async && !mActive) begin
      readyWho = pickOwner(reqValid, mStart);
      if (readyWho >= 0) expReady = 3'b001 << readyWho;
    end
    checkOutput("req_ready", reqReady, expReady);
    checkOutput("rsp_valid", rspValid, mRspValid);
    if (mRspValid != 0) begin
      checkOutput("rsp_rdata", rspRdata, mRspData);
      checkOutput("rsp_err", rspErr, mRspErr);
    end
    checkOutput("dram_oe", dramOe, mActive && !mXfer);
    if (mActive && !mXfer) begin
      checkOutput("dram_addr", dramAddr, mAddr);
      checkOutput("dram_wdata", dramWdata, mWdata);
      checkOutput("dram_we", dramWe, mWe);
    end
    checkOutput("timeout_flag", timeoutFlag, mFlag);
  end

  logic [2:0] accMask = '0;
  bit         xferSeen = 0;
  int         xferCount = 0;
  int         oeCycles = 0;

  always @(negedge clk) begin
    accMask = reqValid & reqReady;
    xferSeen = dramOe && !dramBusy;
    if (dramOe) oeCycles++;
    if (dramOe && !dramBusy) xferCount++;
  end

  always @(posedge clk) cyc++;

  int dueQ[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic newPayload(input int i);
    reqValid[i] = 1'b1;
    reqAddr[i*ADDR_W +: ADDR_W] = $urandom;
    reqWdata[i*DATA_W +: DATA_W] = $urandom;
    reqWe[i*BE_W +: BE_W] = ($urandom_range(1, 0) == 1) ? BE_W'($urandom) : '0;
  endtask

  // One cycle of randomized requester and DRAM-side behaviour, then advance the clock.
  task automatic applyStimulus(input bit holdAll, input int busyPct, input int neverPct, input int maxLat);
    for (int i = 0; i < 3; i++) begin
      if (holdAll) reqValid[i] = 1'b1;
      else if (accMask[i]) begin
        if ($urandom_range(1, 0) == 1) newPayload(i);
        else reqValid[i] = 1'b0;
      end else if (!reqValid[i] && $urandom_range(99, 0) < 30) newPayload(i);
    end
    if (xferSeen && int'($urandom_range(99, 0)) >= neverPct)
      dueQ.push_back(cyc + int'($urandom_range(maxLat, 1)));
    dramValid = 1'b0;
    for (int k = 0; k < dueQ.size(); k++) begin
      if (dueQ[k] <= cyc + 1) begin
        dramValid = 1'b1;
        dueQ.delete(k);
        break;
      end
    end
    dramRdata = $urandom;
    dramBusy = (int'($urandom_range(99, 0)) < busyPct);
    tick();
  endtask

  int ob;
  int xb;
  int waitEdges;
  int owners[$];
  int expOwn[6];

  initial begin
    rst_async = 1'b1;
    repeat (3) @(posedge clk);
    #1 reqValid = 3'b001;
    @(negedge clk);
    checkOutput("reset_req_ready", reqReady, 3'b000);
    checkOutput("reset_rsp_valid", rspValid, 3'b000);
    checkOutput("reset_rsp_rdata", rspRdata, 0);
    checkOutput("reset_rsp_err", rspErr, 0);
    checkOutput("reset_dram_oe", dramOe, 0);
    checkOutput("reset_dram_addr", dramAddr, 0);
    checkOutput("reset_dram_wdata", dramWdata, 0);
    checkOutput("reset_dram_we", dramWe, 0);
    checkOutput("reset_timeout_flag", timeoutFlag, 0);
    tick();
    reqValid = 3'b000;
    rst_async = 1'b0;

    // Single read, response five cycles after the transfer.
    tick();
    reqAddr[1*ADDR_W +: ADDR_W] = 32'h100;
    reqWe[1*BE_W +: BE_W] = '0;
    reqValid = 3'b010;
    @(negedge clk);
    checkOutput("read_ready", reqReady, 3'b010);
    tick();
    reqValid = 3'b000;
    ob = oeCycles; xb = xferCount;
    @(negedge clk);
    checkOutput("read_oe", dramOe, 1);
    checkOutput("read_addr", dramAddr, 32'h100);
    checkOutput("read_we", dramWe, 0);
    tick();
    @(negedge clk);
    checkOutput("read_oe_drop", dramOe, 0);
    repeat (4) tick();
    dramValid = 1'b1;
    dramRdata = 32'hDEADBEEF;
    tick();
    dramValid = 1'b0;
    @(negedge clk);
    checkOutput("read_rsp_valid", rspValid, 3'b010);
    checkOutput("read_rsp_rdata", rspRdata, 32'hDEADBEEF);
    checkOutput("read_rsp_err", rspErr, 0);
    tick();
    @(negedge clk);
    checkOutput("read_rsp_pulse", rspValid, 3'b000);
    checkOutput("read_oe_cycles", oeCycles - ob, 1);

    // Busy stall: command must hold steady while the DRAM is busy.
    tick();
    reqAddr[2*ADDR_W +: ADDR_W] = 32'h200;
    reqWdata[2*DATA_W +: DATA_W] = 32'hA5A50F0F;
    reqWe[2*BE_W +: BE_W] = 4'hF;
    reqValid = 3'b100;
    dramBusy = 1'b1;
    @(negedge clk);
    checkOutput("stall_ready", reqReady, 3'b100);
    tick();
    reqValid = 3'b000;
    ob = oeCycles; xb = xferCount;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stall_oe", dramOe, 1);
      checkOutput("stall_addr", dramAddr, 32'h200);
      checkOutput("stall_wdata", dramWdata, 32'hA5A50F0F);
      checkOutput("stall_we", dramWe, 4'hF);
      tick();
    end
    dramBusy = 1'b0;
    tick();
    dramValid = 1'b1;
    dramRdata = 32'h0BADF00D;
    tick();
    dramValid = 1'b0;
    @(negedge clk);
    checkOutput("stall_rsp_valid", rspValid, 3'b100);
    checkOutput("stall_rsp_rdata", rspRdata, 32'h0BADF00D);
    checkOutput("stall_transfers", xferCount - xb, 1);
    checkOutput("stall_oe_cycles", oeCycles - ob, 5);

    // Partial write.
    tick();
    reqAddr[0 +: ADDR_W] = 32'h40;
    reqWdata[0 +: DATA_W] = 32'h12345678;
    reqWe[0 +: BE_W] = 4'b0011;
    reqValid = 3'b001;
    @(negedge clk);
    checkOutput("write_ready", reqReady, 3'b001);
    tick();
    reqValid = 3'b000;
    @(negedge clk);
    checkOutput("write_we", dramWe, 4'b0011);
    checkOutput("write_wdata", dramWdata, 32'h12345678);
    tick();
    dramValid = 1'b1;
    dramRdata = '0;
    tick();
    dramValid = 1'b0;
    @(negedge clk);
    checkOutput("write_rsp_valid", rspValid, 3'b001);
    checkOutput("write_rsp_err", rspErr, 0);

    // Timeout with no DRAM response, then a late response that must be dropped.
    tick();
    reqAddr[2*ADDR_W +: ADDR_W] = 32'h300;
    reqWe[2*BE_W +: BE_W] = '0;
    reqValid = 3'b100;
    tick();
    reqValid = 3'b000;
    tick();
    waitEdges = 0;
    while (waitEdges < 40) begin
      @(negedge clk);
      if (rspValid != 3'b000) break;
      tick();
      waitEdges++;
    end
    checkOutput("timeout_latency", waitEdges, TIMEOUT);
    checkOutput("timeout_rsp_valid", rspValid, 3'b100);
    checkOutput("timeout_rsp_err", rspErr, 1);
    checkOutput("timeout_rsp_rdata", rspRdata, 0);
    checkOutput("timeout_flag_set", timeoutFlag, 1);
    tick();
    dramValid = 1'b1;
    dramRdata = 32'h77;
    tick();
    dramValid = 1'b0;
    @(negedge clk);
    checkOutput("late_rsp_dropped", rspValid, 3'b000);
    checkOutput("timeout_flag_sticky", timeoutFlag, 1);

    // Reset in the middle of WAIT, then a normal transaction.
    tick();
    reqAddr[1*ADDR_W +: ADDR_W] = 32'h500;
    reqValid = 3'b010;
    tick();
    reqValid = 3'b000;
    repeat (3) tick();
    rst_async = 1'b1;
    #1;
    checkOutput("midreset_oe", dramOe, 0);
    checkOutput("midreset_addr", dramAddr, 0);
    checkOutput("midreset_rsp_valid", rspValid, 3'b000);
    checkOutput("midreset_flag", timeoutFlag, 0);
    checkOutput("midreset_ready", reqReady, 3'b000);
    tick();
    tick();
    rst_async = 1'b0;
    reqAddr[0 +: ADDR_W] = 32'h600;
    reqWe[0 +: BE_W] = '0;
    reqValid = 3'b001;
    @(negedge clk);
    checkOutput("postreset_ready", reqReady, 3'b001);
    tick();
    reqValid = 3'b000;
    tick();
    dramValid = 1'b1;
    dramRdata = 32'hCAFEF00D;
    tick();
    dramValid = 1'b0;
    @(negedge clk);
    checkOutput("postreset_rsp_valid", rspValid, 3'b001);
    checkOutput("postreset_rsp_rdata", rspRdata, 32'hCAFEF00D);

    // Contention: all three requesters held active from a fresh reset.
    tick();
    rst_async = 1'b1;
    tick();
    tick();
    dueQ.delete();
    rst_async = 1'b0;
`ifdef DRAM_ARB_RR_EN
    expOwn = '{0, 1, 2, 0, 1, 2};
`else
    expOwn = '{0, 0, 0, 0, 0, 0};
`endif
    for (int c = 0; c < 400 && owners.size() < 6; c++) begin
      applyStimulus(1'b1, 0, 0, 3);
      if (accMask != 3'b000) owners.push_back(accMask[2] ? 2 : (accMask[1] ? 1 : 0));
    end
    checkOutput("contention_count", owners.size(), 6);
    for (int i = 0; i < owners.size() && i < 6; i++)
      checkOutput($sformatf("contention_owner%0d", i), owners[i], expOwn[i]);

    // Randomized traffic with busy stalls, variable latency and lost responses.
    for (int c = 0; c < 3000; c++) applyStimulus(1'b0, 25, 10, 22);

    reqValid = 3'b000;
    repeat (2) tick();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
